// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the controller state encoding.
package axi4_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_WR   = 2'd1;
    localparam logic [1:0] STATE_RD   = 2'd2;
    localparam logic [1:0] STATE_RSP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_WR   = STATE_WR,
        ST_RD   = STATE_RD,
        ST_RSP  = STATE_RSP
    } axi_state_e;

    // EXOKAY is not expected from an AXI4-Lite slave, so it counts as an error too.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_chan_reg.sv
// Valid-hold register for one AXI request channel: loads a payload, holds it
// stable with valid asserted, and drops valid on the ready handshake.
module axi4_lite_chan_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [width-1:0] dout
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4_lite_master_ctrl.sv
// AXI4-Lite initiator: one local command at a time becomes one AXI write or read,
// and the slave's answer is returned as a single response word.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WR    | AW/W pending or done, waiting for B
// RD    | AR pending or done, waiting for R
// RSP   | response held on rsp_* until rsp_ready
module axi4_lite_master_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int         addr_width    = 12,
    parameter logic [2:0] prot_value    = 3'b000,
    parameter int         err_cnt_width = 16
) (
    input  logic                     m_axi_aclk,
    input  logic                     m_axi_areset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [addr_width-1:0]    cmd_addr,
    input  logic [31:0]              cmd_wdata,
    input  logic [3:0]               cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     busy,
    output logic [err_cnt_width-1:0] err_cnt,
    output logic [addr_width-1:0]    m_axi_awaddr,
    output logic [2:0]               m_axi_awprot,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [31:0]              m_axi_wdata,
    output logic [3:0]               m_axi_wstrb,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [addr_width-1:0]    m_axi_araddr,
    output logic [2:0]               m_axi_arprot,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam logic [err_cnt_width-1:0] err_one = {{(err_cnt_width-1){1'b0}}, 1'b1};

    axi_state_e state;
    logic       accept;
    logic       aw_pend_nxt, w_pend_nxt, ar_pend_nxt;

    assign accept       = (state == ST_IDLE) && cmd_ready && cmd_valid;
    assign busy         = (state != ST_IDLE);
    assign m_axi_awprot = prot_value;
    assign m_axi_arprot = prot_value;

    // Pending flags as they will be after this edge; lets bready/rready be registered
    // yet rise in the cycle right after the last request handshake.
    assign aw_pend_nxt = m_axi_awvalid && !m_axi_awready;
    assign w_pend_nxt  = m_axi_wvalid && !m_axi_wready;
    assign ar_pend_nxt = m_axi_arvalid && !m_axi_arready;

    axi4_lite_chan_reg #(.width(addr_width)) u_aw (
        .clk   (m_axi_aclk),
        .reset (m_axi_areset),
        .load  (accept && cmd_we),
        .din   (cmd_addr),
        .ready (m_axi_awready),
        .valid (m_axi_awvalid),
        .dout  (m_axi_awaddr)
    );

    axi4_lite_chan_reg #(.width(36)) u_w (
        .clk   (m_axi_aclk),
        .reset (m_axi_areset),
        .load  (accept && cmd_we),
        .din   ({cmd_wstrb, cmd_wdata}),
        .ready (m_axi_wready),
        .valid (m_axi_wvalid),
        .dout  ({m_axi_wstrb, m_axi_wdata})
    );

    axi4_lite_chan_reg #(.width(addr_width)) u_ar (
        .clk   (m_axi_aclk),
        .reset (m_axi_areset),
        .load  (accept && !cmd_we),
        .din   (cmd_addr),
        .ready (m_axi_arready),
        .valid (m_axi_arvalid),
        .dout  (m_axi_araddr)
    );

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b0;
            m_axi_bready <= 1'b0;
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= '0;
            err_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        state     <= cmd_we ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    m_axi_bready <= !aw_pend_nxt && !w_pend_nxt;
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_valid    <= 1'b1;
                        if (resp_is_err(m_axi_bresp) && (err_cnt != '1))
                            err_cnt <= err_cnt + err_one;
                        state <= ST_RSP;
                    end
                end
                ST_RD: begin
                    m_axi_rready <= !ar_pend_nxt;
                    if (m_axi_rvalid && m_axi_rready) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_valid    <= 1'b1;
                        if (resp_is_err(m_axi_rresp) && (err_cnt != '1))
                            err_cnt <= err_cnt + err_one;
                        state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Bench for axi4_lite_master_ctrl: directed commands against a small AXI4-Lite
// memory slave, responses checked by a scoreboard monitor.
module tb_axi4_lite_master_ctrl;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [2:0]  err_cnt;
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic [1:0]  slv_bresp, slv_rresp;
    logic [31:0] mem [0:1023];
    logic        got_aw, got_w;
    logic [11:0] aw_l;
    logic [31:0] wd_l;
    logic [3:0]  ws_l;
    logic        aw_hs, w_hs;
    logic [11:0] slv_wa;
    logic [31:0] slv_wd;
    logic [3:0]  slv_ws;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi4_lite_master_ctrl #(
        .addr_width(12), .prot_value(3'b010), .err_cnt_width(3)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy(busy), .err_cnt(err_cnt),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    // Memory slave: B one cycle after both AW and W are taken, R one cycle after AR.
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign slv_wa = got_aw ? aw_l : awaddr;
    assign slv_wd = got_w ? wd_l : wdata;
    assign slv_ws = got_w ? ws_l : wstrb;

    always @(posedge clk) begin
        if (areset) begin
            bvalid <= 1'b0; rvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_l <= '0; wd_l <= '0; ws_l <= '0;
        end else begin
            if (aw_hs) begin aw_l <= awaddr; got_aw <= 1'b1; end
            if (w_hs) begin wd_l <= wdata; ws_l <= wstrb; got_w <= 1'b1; end
            if (bvalid && bready) bvalid <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs) && !bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (slv_ws[b]) mem[slv_wa[11:2]][8*b +: 8] <= slv_wd[8*b +: 8];
                bvalid <= 1'b1;
                bresp  <= slv_bresp;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready && !rvalid) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[11:2]];
                rresp  <= slv_rresp;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response handshake pops one expected entry.
    always @(negedge clk) begin
        if (!areset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h resp %0d with empty queue", rsp_rdata, rsp_resp);
            end else begin
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, sb[0].rdata});
                check("rsp_resp", {62'd0, rsp_resp}, {62'd0, sb[0].resp});
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic we, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e_rdata, input logic [1:0] e_resp);
        bit ok = 0;
        sb.push_back('{rdata: e_rdata, resp: e_resp});
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready never rose for addr 0x%0h", a);
        end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (!busy && sb.size() == 0) ok = 1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: busy=%0d pending=%0d", busy, sb.size());
        end
    endtask

    task automatic run(input logic we, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e_rdata, input logic [1:0] e_resp);
        issue(we, a, d, s, e_rdata, e_resp);
        wait_done();
    endtask

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        slv_bresp = 2'b00; slv_rresp = 2'b00;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_valids", {60'd0, awvalid, wvalid, arvalid, rsp_valid}, 64'd0);
        check("rst_err_busy", {60'd0, err_cnt, busy}, 64'd0);
        check("rst_awaddr", {52'd0, awaddr}, 64'd0);
        @(posedge clk); #1;
        areset = 1'b0;

        // Write with zero-wait slave, cycle-exact
        sb.push_back('{rdata: 32'h0, resp: 2'b00});
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 12'h010; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        @(negedge clk);
        check("wr_c0_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("wr_c1_valids", {61'd0, awvalid, wvalid, bready}, 64'b110);
        check("wr_c1_awaddr", {52'd0, awaddr}, 64'h010);
        check("wr_c1_wdata", {28'd0, wstrb, wdata}, 64'hF_DEADBEEF);
        check("wr_c1_awprot", {61'd0, awprot}, 64'b010);
        @(negedge clk);
        check("wr_c2_b", {61'd0, awvalid, bvalid, bready}, 64'b011);
        @(negedge clk);
        check("wr_c3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        wait_done();
        check("wr_mem4", {32'd0, mem[4]}, 64'hDEADBEEF);

        // Read back, cycle-exact
        sb.push_back('{rdata: 32'hDEADBEEF, resp: 2'b00});
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 12'h010;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rd_c1_arvalid", {63'd0, arvalid}, 64'd1);
        check("rd_c1_araddr_prot", {49'd0, arprot, araddr}, {49'd0, 3'b010, 12'h010});
        @(negedge clk);
        check("rd_c2_r", {62'd0, rvalid, rready}, 64'b11);
        @(negedge clk);
        check("rd_c3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        wait_done();

        // Split handshake: W taken 3 cycles before AW; partial strobe
        awready = 1'b0;
        sb.push_back('{rdata: 32'h0, resp: 2'b00});
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 12'h020; cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("split_c1_valids", {62'd0, awvalid, wvalid}, 64'b11);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("split_hold_valids", {61'd0, awvalid, wvalid, bready}, 64'b100);
            check("split_hold_awaddr", {52'd0, awaddr}, 64'h020);
        end
        @(posedge clk); #1;
        awready = 1'b1;
        @(negedge clk);
        check("split_c4_bready", {62'd0, awvalid, bready}, 64'b10);
        @(negedge clk);
        check("split_c5_b", {61'd0, awvalid, bvalid, bready}, 64'b011);
        wait_done();
        run(1'b0, 12'h020, 32'h0, 4'h0, 32'h00005678, 2'b00);

        // Backpressure on rsp with a new command waiting
        rsp_ready = 1'b0;
        issue(1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        @(posedge clk); #1;
        sb.push_back('{rdata: 32'h0, resp: 2'b00});
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 12'h030; cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {30'd0, rsp_valid, cmd_ready, rsp_rdata}, {30'd0, 2'b10, 32'hDEADBEEF});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        check("bp_idle_ready", {62'd0, cmd_ready, busy}, 64'b10);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_next_accepted", {62'd0, busy, awvalid}, 64'b11);
        wait_done();
        run(1'b0, 12'h030, 32'h0, 4'h0, 32'hA5A5A5A5, 2'b00);
        check("err_cnt_clean", {61'd0, err_cnt}, 64'd0);

        // Error counting and saturation (3-bit counter)
        slv_bresp = 2'b10;
        run(1'b1, 12'h100, 32'h11111111, 4'hF, 32'h0, 2'b10);
        run(1'b1, 12'h100, 32'h11111111, 4'hF, 32'h0, 2'b10);
        slv_rresp = 2'b11;
        run(1'b0, 12'h100, 32'h0, 4'h0, 32'h11111111, 2'b11);
        check("err_cnt_3", {61'd0, err_cnt}, 64'd3);
        for (int i = 0; i < 3; i++) run(1'b1, 12'h104, 32'h2, 4'hF, 32'h0, 2'b10);
        check("err_cnt_6", {61'd0, err_cnt}, 64'd6);
        for (int i = 0; i < 2; i++) run(1'b1, 12'h104, 32'h2, 4'hF, 32'h0, 2'b10);
        check("err_cnt_sat", {61'd0, err_cnt}, 64'd7);
        slv_bresp = 2'b00; slv_rresp = 2'b00;

        // Reset in the middle of a write
        awready = 1'b0; wready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 12'h040; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_awvalid", {62'd0, awvalid, busy}, 64'b11);
        @(posedge clk); #1;
        areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_state", {59'd0, awvalid, wvalid, busy, cmd_ready, rsp_valid}, 64'd0);
        check("mid_rst_err", {61'd0, err_cnt}, 64'd0);
        @(posedge clk); #1;
        areset = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        run(1'b1, 12'h044, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00);
        run(1'b0, 12'h044, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00);
        check("sb_drained", {32'd0, sb.size()}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/axi4_lite_master_ctrl.md
Name: axi4_lite_master_ctrl

Overview:
AXI4-Lite initiator: turns single-word commands from local logic (TRNG sampler, self-test sequencer) into AXI4-Lite write or read transactions. Drives axi4_lite_slave_ctrl/BRAM and any other AXI4-Lite slave. Returns a response word per command. One transaction outstanding at a time; commands are never reordered.

Parameters:
addr_width, 12, AXI/command address width in bits
prot_value, 3'b000, constant value driven on m_axi_awprot and m_axi_arprot
err_cnt_width, 16, width of the saturating error counter

Ports:
m_axi_aclk  in  1  sole clock
m_axi_areset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted this cycle when cmd_valid=1
cmd_we  in  1  1=write, 0=read
cmd_addr  in  addr_width  byte address
cmd_wdata  in  32  write data
cmd_wstrb  in  4  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP of the transaction
busy  out  1  state != IDLE
err_cnt  out  err_cnt_width  saturating count of responses != 2'b00
m_axi_awaddr/awprot/awvalid, m_axi_wdata/wstrb/wvalid, m_axi_bready, m_axi_araddr/arprot/arvalid, m_axi_rready  out  per AXI4-Lite
m_axi_awready, m_axi_wready, m_axi_bresp/bvalid, m_axi_arready, m_axi_rdata/rresp/rvalid  in  per AXI4-Lite

Behaviour:
- Reset (synchronous, active-high; takes effect at the next clock edge, including mid-transaction): state=IDLE. All valid and ready outputs are 0, rsp_* = 0, err_cnt=0, and the address and data registers are 0.
- FSM states: IDLE, WR, RD, RSP.
- IDLE: cmd_ready=1. When cmd_valid=1, latch cmd_*. If cmd_we=1, go to WR and set aw_pend=w_pend=1. Otherwise go to RD and set ar_pend=1.
- All AXI outputs are registered. awvalid=aw_pend, wvalid=w_pend, arvalid=ar_pend. Address, data and strobe stay stable while the matching valid is high.
- WR:
  - aw_pend clears on awvalid&awready; w_pend clears on wvalid&wready. The two clear independently, in either order or in the same cycle.
  - bready = ~aw_pend & ~w_pend.
  - On bvalid&bready: rsp_resp<=bresp, rsp_rdata<=0, go to RSP.
- RD:
  - ar_pend clears on arvalid&arready.
  - rready = ~ar_pend.
  - On rvalid&rready: rsp_rdata<=rdata, rsp_resp<=rresp, go to RSP.
- RSP:
  - rsp_valid=1, held with stable data until rsp_ready=1, then go to IDLE.
  - cmd_ready=0, so no back-to-back overlap: the next command is accepted at the earliest one cycle after the rsp handshake.
- Latency with a zero-wait slave:
  - Command accepted at cycle 0; AW/W or AR valid at cycle 1.
  - Write: B at cycle 2.
  - rsp_valid at cycle 3 for write; for read, rsp_valid at cycle 3 if the slave returns R at cycle 2.
- err_cnt increments by 1 when leaving WR or RD with a response != 2'b00, and saturates at all-ones.
- Early B: bvalid seen while aw_pend or w_pend is still set is not accepted, because bready=0; it waits.
- Input ready/valid signals arriving in IDLE or RSP are ignored.

Decomposition:
- Shared package axi4_lite_pkg:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_EXOKAY=2'b01, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
  - FSM state encoding constants, also used by the slave's future FSM rework.
- Natural sub-module: axi4_lite_chan_reg (valid-hold register with pend flag, data hold and clear-on-handshake), instantiated for the AW, W and AR channels.

Test Plan:
- Write to zero-wait slave:
  - Stimulus: cmd_we=1, addr=0x010, wdata=0xDEADBEEF, wstrb=0xF.
  - Response: awvalid/wvalid at cycle 1, bready at cycle 2, rsp_valid at cycle 3 with resp=0, rdata=0; BRAM word 4 = 0xDEADBEEF.
- Read back:
  - Stimulus: cmd_we=0, addr=0x010.
  - Response: arvalid at cycle 1, rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Split handshake:
  - Stimulus: slave asserts wready 3 cycles before awready.
  - Response: wvalid drops after the W handshake; awvalid and awaddr stay stable; bready stays 0 until the AW handshake; single rsp.
- Backpressure:
  - Stimulus: rsp_ready held 0 for 5 cycles with cmd_valid=1.
  - Response: rsp_valid and rsp_rdata stable; cmd_ready=0 throughout; the next command is accepted only after rsp_ready.
- Error count:
  - Stimulus: slave returns bresp=2'b10 twice, then rresp=2'b11 once.
  - Response: err_cnt=3. After forcing err_cnt to all-ones minus 1 and 2 more errors, err_cnt=all-ones.
- Reset mid-operation:
  - Stimulus: assert m_axi_areset while awvalid=1 in WR.
  - Response: the next edge gives IDLE, all valids 0, cmd_ready=1 after deassertion, err_cnt=0.
